// File: rtl/amber_mmu_ptw_pkg.sv
// Shared definitions for the amber_mmu page-table walker: PTE layout, fault codes,
// walker states and the PTE word-address helper.
package amber_mmu_ptw_pkg;

   localparam int unsigned LEVELS    = 4;
   localparam int unsigned IDX_W     = 9;
   localparam int unsigned VPN_W     = LEVELS * IDX_W;
   localparam int unsigned PPN_W     = 30;
   localparam int unsigned ADDR_W    = 48;
   localparam int unsigned WORD_W    = 24;
   localparam int unsigned PTE_V_BIT = 18;
   localparam int unsigned PTE_G_BIT = 19;

   typedef enum logic [2:0] {
      FLT_NOTPRESENT = 3'd0,
      FLT_PERM       = 3'd1,
      FLT_MALFORMED  = 3'd2,
      FLT_BUS        = 3'd3
   } fault_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_LO,
      ST_WAIT_LO,
      ST_REQ_HI,
      ST_WAIT_HI,
      ST_CHECK,
      ST_DONE,
      ST_DRAIN
   } state_e;

   // Index for a level, most-significant 9-bit group first.
   function automatic logic [IDX_W-1:0] vpn_index(input logic [VPN_W-1:0] vpn,
                                                  input logic [1:0]       level);
      logic [VPN_W-1:0] sh;
      sh = vpn >> (IDX_W * (LEVELS - 1 - int'(level)));
      return sh[IDX_W-1:0];
   endfunction

   // Word address of the low PTE word; each PTE occupies two consecutive words.
   function automatic logic [ADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] tbl_ppn,
                                                  input logic [VPN_W-1:0] vpn,
                                                  input logic [1:0]       level);
      return {6'd0, tbl_ppn, 12'h000} + {38'd0, vpn_index(vpn, level), 1'b0};
   endfunction

endpackage

// File: rtl/amber_mmu_ptw.sv
// Hardware page-table walker: takes one TLB miss, walks the 4-level radix table
// through a single-outstanding read port, and returns a TLB refill or a fault.
module amber_mmu_ptw
   import amber_mmu_ptw_pkg::*;
(
   input  logic        iw_clk,
   input  logic        iw_rst,
   input  logic [29:0] iw_root_ppn,
   input  logic        iw_abort,
   input  logic        iw_walk_req_valid,
   output logic        ow_walk_req_ready,
   input  logic [35:0] iw_walk_vpn,
   input  logic        iw_walk_is_dtlb,
   input  logic [15:0] iw_walk_asid,
   output logic        ow_walk_done,
   output logic        ow_walk_fault,
   output logic [2:0]  ow_walk_fault_code,
   output logic        ow_fill_valid,
   output logic        ow_fill_is_dtlb,
   output logic [35:0] ow_fill_vpn,
   output logic [29:0] ow_fill_ppn,
   output logic [5:0]  ow_fill_perm,
   output logic [7:0]  ow_fill_asid,
   output logic        ow_fill_global,
   output logic        ow_mem_req_valid,
   input  logic        iw_mem_req_ready,
   output logic [47:0] ow_mem_req_addr,
   input  logic        iw_mem_resp_valid,
   input  logic [23:0] iw_mem_resp_data,
   input  logic        iw_mem_resp_err
);

   state_e            state;
   logic [35:0]       vpn_q;
   logic              is_dtlb_q;
   logic [7:0]        asid_q;
   logic [1:0]        level_q;
   logic [29:0]       tbl_q;
   logic [23:0]       lo_q;
   logic [23:0]       hi_q;

   logic              pte_v;
   logic              pte_g;
   logic              pte_leaf;
   logic [5:0]        pte_perm;
   logic [29:0]       pte_ppn;
   logic              last_level;
   logic              unused_bits;

   always_comb begin
      pte_v      = hi_q[PTE_V_BIT];
      pte_g      = hi_q[PTE_G_BIT];
      pte_perm   = lo_q[5:0];
      pte_leaf   = |lo_q[2:0];
      pte_ppn    = {hi_q[17:0], lo_q[23:12]};
      last_level = (level_q == 2'(LEVELS - 1));
   end

   assign unused_bits = &{1'b0, iw_walk_asid[15:8], lo_q[11:6], hi_q[23:20]};

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         state              <= ST_IDLE;
         vpn_q              <= '0;
         is_dtlb_q          <= 1'b0;
         asid_q             <= '0;
         level_q            <= '0;
         tbl_q              <= '0;
         lo_q               <= '0;
         hi_q               <= '0;
         ow_walk_req_ready  <= 1'b1;
         ow_walk_done       <= 1'b0;
         ow_walk_fault      <= 1'b0;
         ow_walk_fault_code <= '0;
         ow_fill_valid      <= 1'b0;
         ow_fill_is_dtlb    <= 1'b0;
         ow_fill_vpn        <= '0;
         ow_fill_ppn        <= '0;
         ow_fill_perm       <= '0;
         ow_fill_asid       <= '0;
         ow_fill_global     <= 1'b0;
         ow_mem_req_valid   <= 1'b0;
         ow_mem_req_addr    <= '0;
      end else begin
         ow_walk_done  <= 1'b0;
         ow_fill_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iw_walk_req_valid && !iw_abort) begin
                  vpn_q             <= iw_walk_vpn;
                  is_dtlb_q         <= iw_walk_is_dtlb;
                  asid_q            <= iw_walk_asid[7:0];
                  level_q           <= '0;
                  tbl_q             <= iw_root_ppn;
                  ow_mem_req_addr   <= pte_addr(iw_root_ppn, iw_walk_vpn, 2'd0);
                  ow_mem_req_valid  <= 1'b1;
                  ow_walk_req_ready <= 1'b0;
                  state             <= ST_REQ_LO;
               end
            end

            ST_REQ_LO, ST_REQ_HI: begin
               // Once the handshake happens a response is owed, so abort must drain it.
               if (iw_mem_req_ready) begin
                  ow_mem_req_valid <= 1'b0;
                  if (iw_abort)
                     state <= ST_DRAIN;
                  else if (state == ST_REQ_LO)
                     state <= ST_WAIT_LO;
                  else
                     state <= ST_WAIT_HI;
               end else if (iw_abort) begin
                  ow_mem_req_valid  <= 1'b0;
                  ow_walk_req_ready <= 1'b1;
                  state             <= ST_IDLE;
               end
            end

            ST_WAIT_LO, ST_WAIT_HI: begin
               if (iw_mem_resp_valid) begin
                  if (iw_abort) begin
                     ow_walk_req_ready <= 1'b1;
                     state             <= ST_IDLE;
                  end else if (iw_mem_resp_err) begin
                     ow_walk_done       <= 1'b1;
                     ow_walk_fault      <= 1'b1;
                     ow_walk_fault_code <= FLT_BUS;
                     state              <= ST_DONE;
                  end else if (state == ST_WAIT_LO) begin
                     lo_q             <= iw_mem_resp_data;
                     ow_mem_req_addr  <= ow_mem_req_addr + 48'd1;
                     ow_mem_req_valid <= 1'b1;
                     state            <= ST_REQ_HI;
                  end else begin
                     hi_q  <= iw_mem_resp_data;
                     state <= ST_CHECK;
                  end
               end else if (iw_abort) begin
                  state <= ST_DRAIN;
               end
            end

            ST_CHECK: begin
               if (iw_abort) begin
                  ow_walk_req_ready <= 1'b1;
                  state             <= ST_IDLE;
               end else if (!pte_v) begin
                  ow_walk_done       <= 1'b1;
                  ow_walk_fault      <= 1'b1;
                  ow_walk_fault_code <= FLT_NOTPRESENT;
                  state              <= ST_DONE;
               end else if (pte_leaf != last_level) begin
                  ow_walk_done       <= 1'b1;
                  ow_walk_fault      <= 1'b1;
                  ow_walk_fault_code <= FLT_MALFORMED;
                  state              <= ST_DONE;
               end else if (!pte_leaf) begin
                  tbl_q            <= pte_ppn;
                  level_q          <= level_q + 2'd1;
                  ow_mem_req_addr  <= pte_addr(pte_ppn, vpn_q, level_q + 2'd1);
                  ow_mem_req_valid <= 1'b1;
                  state            <= ST_REQ_LO;
               end else begin
                  ow_walk_done       <= 1'b1;
                  ow_walk_fault      <= 1'b0;
                  ow_walk_fault_code <= '0;
                  ow_fill_valid      <= 1'b1;
                  ow_fill_is_dtlb    <= is_dtlb_q;
                  ow_fill_vpn        <= vpn_q;
                  ow_fill_ppn        <= pte_ppn;
                  ow_fill_perm       <= pte_perm;
                  ow_fill_asid       <= asid_q;
                  ow_fill_global     <= pte_g;
                  state              <= ST_DONE;
               end
            end

            ST_DONE: begin
               ow_walk_req_ready <= 1'b1;
               state             <= ST_IDLE;
            end

            ST_DRAIN: begin
               if (iw_mem_resp_valid) begin
                  ow_walk_req_ready <= 1'b1;
                  state             <= ST_IDLE;
               end
            end

            default: begin
               ow_mem_req_valid  <= 1'b0;
               ow_walk_req_ready <= 1'b1;
               state             <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amber_mmu_ptw.sv
// Directed bench for amber_mmu_ptw: a behavioural word memory answers reads, and
// each scenario task checks fills, faults, read counts and abort/reset behaviour.
module tb_amber_mmu_ptw;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] root_ppn;
   logic        abort;
   logic        walk_req_valid;
   logic        walk_req_ready;
   logic [35:0] walk_vpn;
   logic        walk_is_dtlb;
   logic [15:0] walk_asid;
   logic        walk_done;
   logic        walk_fault;
   logic [2:0]  walk_fault_code;
   logic        fill_valid;
   logic        fill_is_dtlb;
   logic [35:0] fill_vpn;
   logic [29:0] fill_ppn;
   logic [5:0]  fill_perm;
   logic [7:0]  fill_asid;
   logic        fill_global;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [47:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [23:0] mem_resp_data;
   logic        mem_resp_err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          reads_cnt = 0;
   int          done_cnt = 0;
   int          fill_cnt = 0;
   int          done_cyc = 0;
   int          last_resp_cyc = 0;
   int          lat = 1;
   logic        err_en = 1'b0;
   logic [47:0] err_addr = '0;
   logic [47:0] read_log[$];
   logic [23:0] mem[logic [47:0]];

   amber_mmu_ptw dut (
      .iw_clk             (clk),
      .iw_rst             (rst),
      .iw_root_ppn        (root_ppn),
      .iw_abort           (abort),
      .iw_walk_req_valid  (walk_req_valid),
      .ow_walk_req_ready  (walk_req_ready),
      .iw_walk_vpn        (walk_vpn),
      .iw_walk_is_dtlb    (walk_is_dtlb),
      .iw_walk_asid       (walk_asid),
      .ow_walk_done       (walk_done),
      .ow_walk_fault      (walk_fault),
      .ow_walk_fault_code (walk_fault_code),
      .ow_fill_valid      (fill_valid),
      .ow_fill_is_dtlb    (fill_is_dtlb),
      .ow_fill_vpn        (fill_vpn),
      .ow_fill_ppn        (fill_ppn),
      .ow_fill_perm       (fill_perm),
      .ow_fill_asid       (fill_asid),
      .ow_fill_global     (fill_global),
      .ow_mem_req_valid   (mem_req_valid),
      .iw_mem_req_ready   (mem_req_ready),
      .ow_mem_req_addr    (mem_req_addr),
      .iw_mem_resp_valid  (mem_resp_valid),
      .iw_mem_resp_data   (mem_resp_data),
      .iw_mem_resp_err    (mem_resp_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [23:0] mem_rd(input logic [47:0] a);
      if (mem.exists(a)) return mem[a];
      return '0;
   endfunction

   // Memory model: one outstanding read, answered lat cycles after the handshake.
   initial begin
      bit          pend;
      int          cd;
      logic [47:0] pend_addr;
      pend = 0; cd = 0; pend_addr = '0;
      mem_req_ready = 1'b1;
      mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
         if (rst === 1'b1) pend = 0;
         if (pend) begin
            cd--;
            if (cd == 0) begin
               pend = 0;
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_rd(pend_addr);
               mem_resp_err   = err_en && (pend_addr == err_addr);
               last_resp_cyc  = cyc;
            end
         end
         if (rst !== 1'b1 && mem_req_valid === 1'b1 && mem_req_ready) begin
            pend = 1; cd = lat; pend_addr = mem_req_addr;
            read_log.push_back(mem_req_addr);
            reads_cnt++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (walk_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (fill_valid === 1'b1) fill_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic load_chain(input logic [23:0] l1_lo, input logic [23:0] l1_hi,
                             input logic [23:0] l3_lo, input logic [23:0] l3_hi);
      mem.delete();
      mem[48'h010000] = 24'h011000; mem[48'h010001] = 24'h040000;
      mem[48'h011000] = l1_lo;      mem[48'h011001] = l1_hi;
      mem[48'h012000] = 24'h013000; mem[48'h012001] = 24'h040000;
      mem[48'h013002] = l3_lo;      mem[48'h013003] = l3_hi;
      reads_cnt = 0;
      read_log.delete();
   endtask

   task automatic start_walk(input logic [35:0] vpn, input logic [15:0] asid,
                             input logic dtlb, output int waited);
      waited = 0;
      walk_req_valid = 1'b1; walk_vpn = vpn; walk_asid = asid; walk_is_dtlb = dtlb;
      while (walk_req_ready !== 1'b1 && waited < 50) begin tick(); waited++; end
      if (walk_req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout: ready=%b required 1", walk_req_ready);
      end
      tick();
      walk_req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int start;
      bit seen;
      start = done_cnt;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         if (done_cnt != start) begin seen = 1; break; end
         tick();
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout: no done within 400 cycles, required one");
      end
   endtask

   task automatic test_reset();
      int w;
      w = 0;
      rst = 1'b1; root_ppn = 30'h10; abort = 1'b0;
      walk_req_valid = 1'b0; walk_vpn = '0; walk_is_dtlb = 1'b0; walk_asid = '0;
      repeat (3) tick();
      checks++;
      if (walk_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", walk_req_ready); end
      checks++;
      if ({walk_done, walk_fault, walk_fault_code, fill_valid, fill_is_dtlb, fill_vpn, fill_ppn,
           fill_perm, fill_asid, fill_global, mem_req_valid, mem_req_addr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: done=%b flt=%b code=%0d fv=%b mrv=%b addr=%0h required all 0",
                  walk_done, walk_fault, walk_fault_code, fill_valid, mem_req_valid, mem_req_addr);
      end
      rst = 1'b0;
      tick();
      w = reads_cnt;
      checks++;
      if (w != 0) begin errors++; $display("FAIL reset_no_reads: got %0d required 0", w); end
   endtask

   task automatic test_basic_fill();
      int w;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      start_walk(36'h000000001, 16'h0005, 1'b1, w);
      wait_done();
      checks++;
      if (fill_valid !== 1'b1 || walk_fault !== 1'b0) begin errors++; $display("FAIL fill_pulse: fill=%b fault=%b required 1/0", fill_valid, walk_fault); end
      checks++;
      if (fill_vpn !== 36'h1) begin errors++; $display("FAIL fill_vpn: got %0h required 1", fill_vpn); end
      checks++;
      if (fill_ppn !== 30'h2) begin errors++; $display("FAIL fill_ppn: got %0h required 2", fill_ppn); end
      checks++;
      if (fill_perm !== 6'h07) begin errors++; $display("FAIL fill_perm: got %0h required 07", fill_perm); end
      checks++;
      if ({fill_global, fill_is_dtlb, fill_asid} !== {1'b0, 1'b1, 8'h05}) begin
         errors++; $display("FAIL fill_tag: g=%b d=%b asid=%0h required 0/1/05", fill_global, fill_is_dtlb, fill_asid);
      end
      checks++;
      if (reads_cnt != 8) begin errors++; $display("FAIL basic_reads: got %0d required 8", reads_cnt); end
      checks++;
      if (read_log.size() == 8 && (read_log[0] !== 48'h010000 || read_log[7] !== 48'h013003)) begin
         errors++; $display("FAIL basic_addr: first=%0h last=%0h required 010000/013003", read_log[0], read_log[7]);
      end
      checks++;
      if (done_cyc - last_resp_cyc != 2) begin errors++; $display("FAIL done_latency: got %0d required 2", done_cyc - last_resp_cyc); end
      tick();
      checks++;
      if (walk_done !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b fill=%b required 0/0", walk_done, fill_valid); end
      checks++;
      if (fill_ppn !== 30'h2) begin errors++; $display("FAIL fill_held: got %0h required 2", fill_ppn); end
   endtask

   task automatic test_global();
      int w;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h0C0000);
      start_walk(36'h000000001, 16'h0203, 1'b0, w);
      wait_done();
      checks++;
      if ({fill_valid, fill_global, fill_asid, fill_is_dtlb} !== {1'b1, 1'b1, 8'h03, 1'b0}) begin
         errors++; $display("FAIL global_fill: v=%b g=%b asid=%0h d=%b required 1/1/03/0", fill_valid, fill_global, fill_asid, fill_is_dtlb);
      end
      tick();
   endtask

   task automatic test_not_present();
      int w;
      load_chain(24'h012000, 24'h000012, 24'h002007, 24'h040000);
      start_walk(36'h000000001, 16'h0001, 1'b1, w);
      wait_done();
      checks++;
      if ({walk_fault, walk_fault_code, fill_valid} !== {1'b1, 3'd0, 1'b0}) begin
         errors++; $display("FAIL notpresent: fault=%b code=%0d fill=%b required 1/0/0", walk_fault, walk_fault_code, fill_valid);
      end
      checks++;
      if (reads_cnt != 4) begin errors++; $display("FAIL notpresent_reads: got %0d required 4", reads_cnt); end
      tick();
   endtask

   task automatic test_malformed();
      int w;
      load_chain(24'h000007, 24'h040000, 24'h002007, 24'h040000);
      start_walk(36'h000000001, 16'h0001, 1'b0, w);
      wait_done();
      checks++;
      if ({walk_fault, walk_fault_code, fill_valid} !== {1'b1, 3'd2, 1'b0}) begin
         errors++; $display("FAIL early_leaf: fault=%b code=%0d fill=%b required 1/2/0", walk_fault, walk_fault_code, fill_valid);
      end
      checks++;
      if (reads_cnt != 4) begin errors++; $display("FAIL early_leaf_reads: got %0d required 4", reads_cnt); end
      tick();
      load_chain(24'h012000, 24'h040000, 24'h013000, 24'h040000);
      start_walk(36'h000000001, 16'h0001, 1'b0, w);
      wait_done();
      checks++;
      if ({walk_fault, walk_fault_code, fill_valid} !== {1'b1, 3'd2, 1'b0}) begin
         errors++; $display("FAIL last_nonleaf: fault=%b code=%0d fill=%b required 1/2/0", walk_fault, walk_fault_code, fill_valid);
      end
      checks++;
      if (reads_cnt != 8) begin errors++; $display("FAIL last_nonleaf_reads: got %0d required 8", reads_cnt); end
      tick();
   endtask

   task automatic test_bus_error();
      int w;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      err_en = 1'b1; err_addr = 48'h012000;
      start_walk(36'h000000001, 16'h0001, 1'b1, w);
      wait_done();
      checks++;
      if ({walk_fault, walk_fault_code, fill_valid} !== {1'b1, 3'd3, 1'b0}) begin
         errors++; $display("FAIL bus_err: fault=%b code=%0d fill=%b required 1/3/0", walk_fault, walk_fault_code, fill_valid);
      end
      repeat (4) tick();
      checks++;
      if (reads_cnt != 5) begin errors++; $display("FAIL bus_err_reads: got %0d required 5", reads_cnt); end
      err_en = 1'b0;
   endtask

   task automatic test_abort();
      int w;
      int n;
      int d0;
      int f0;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      lat = 4;
      d0 = done_cnt; f0 = fill_cnt;
      start_walk(36'h000000001, 16'h0001, 1'b1, w);
      n = 0;
      while (reads_cnt < 2 && n < 100) begin tick(); n++; end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (walk_req_ready !== 1'b0) begin errors++; $display("FAIL drain_ready[%0d]: got %b required 0", i, walk_req_ready); end
         tick();
      end
      checks++;
      if (walk_req_ready !== 1'b1) begin errors++; $display("FAIL drain_exit_ready: got %b required 1", walk_req_ready); end
      repeat (3) tick();
      checks++;
      if (done_cnt != d0 || fill_cnt != f0 || reads_cnt != 2) begin
         errors++; $display("FAIL abort_quiet: dones=%0d fills=%0d reads=%0d required +0/+0/2", done_cnt - d0, fill_cnt - f0, reads_cnt);
      end
      lat = 1;
   endtask

   task automatic test_back_to_back();
      int w;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      start_walk(36'h000000001, 16'h0005, 1'b1, w);
      wait_done();
      checks++;
      if (walk_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b required 0", walk_req_ready); end
      mem[48'h013002] = 24'hAB000B;
      mem[48'h013003] = 24'h040005;
      reads_cnt = 0;
      start_walk(36'h000000001, 16'h0011, 1'b0, w);
      checks++;
      if (w != 1) begin errors++; $display("FAIL b2b_accept_wait: got %0d required 1", w); end
      wait_done();
      checks++;
      if ({fill_valid, fill_ppn, fill_perm, fill_asid, fill_is_dtlb} !== {1'b1, 30'h5AB0, 6'h0B, 8'h11, 1'b0}) begin
         errors++; $display("FAIL b2b_fill: v=%b ppn=%0h perm=%0h asid=%0h d=%b required 1/5ab0/0b/11/0",
                            fill_valid, fill_ppn, fill_perm, fill_asid, fill_is_dtlb);
      end
      checks++;
      if (reads_cnt != 8) begin errors++; $display("FAIL b2b_reads: got %0d required 8", reads_cnt); end
      tick();
   endtask

   task automatic test_reset_midwalk();
      int w;
      int n;
      int d0;
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      d0 = done_cnt;
      start_walk(36'h000000001, 16'h0001, 1'b1, w);
      n = 0;
      while (reads_cnt < 3 && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      checks++;
      if (walk_req_ready !== 1'b1 || mem_req_valid !== 1'b0 || walk_done !== 1'b0 || fill_valid !== 1'b0 ||
          fill_ppn !== '0 || mem_req_addr !== '0) begin
         errors++; $display("FAIL midwalk_reset: rdy=%b mrv=%b done=%b fill=%b ppn=%0h addr=%0h required 1/0/0/0/0/0",
                            walk_req_ready, mem_req_valid, walk_done, fill_valid, fill_ppn, mem_req_addr);
      end
      rst = 1'b0;
      repeat (4) tick();
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL midwalk_no_done: got %0d extra required 0", done_cnt - d0); end
      load_chain(24'h012000, 24'h040000, 24'h002007, 24'h040000);
      start_walk(36'h000000001, 16'h0001, 1'b1, w);
      wait_done();
      checks++;
      if (fill_valid !== 1'b1 || fill_ppn !== 30'h2) begin errors++; $display("FAIL post_reset_fill: v=%b ppn=%0h required 1/2", fill_valid, fill_ppn); end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_global();
      test_not_present();
      test_malformed();
      test_bus_error();
      test_abort();
      test_back_to_back();
      test_reset_midwalk();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
